elixirchip_es1_spu_op_acc_mc: RTL and testbench

ELIXIRCHIP_ES1_SPU_OP_ACC_MC -- requirements
Module: elixirchip_es1_spu_op_acc_mc

---
 rtl/elixirchip_es1_spu_op_acc_mc.sv | 150 +++++++++++++++
 tb/tb_elixirchip_es1_spu_op_acc_mc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/elixirchip_es1_spu_op_acc_mc.sv
// Multi-channel signed accumulator: one add/sub per enabled cycle into a selectable channel,
// with optional saturation and a LATENCY-deep registered result path.
module elixirchip_es1_spu_op_acc_mc #(
  parameter int                     CHANNELS    = 4,
  parameter int                     CH_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int                     S_DATA_BITS = 8,
  parameter int                     M_DATA_BITS = 16,
  parameter int                     LATENCY     = 2,
  parameter bit                     SATURATE    = 1'b0,
  parameter logic [M_DATA_BITS-1:0] CLEAR_DATA  = '0,
  parameter string                  DEVICE      = "RTL",
  parameter string                  SIMULATION  = "false",
  parameter string                  DEBUG       = "false"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic                   s_valid,
  input  logic [CH_BITS-1:0]     s_ch,
  input  logic                   s_sub,
  input  logic                   s_clear,
  input  logic                   s_clear_all,
  input  logic [S_DATA_BITS-1:0] s_data,
  output logic                   m_valid,
  output logic [CH_BITS-1:0]     m_ch,
  output logic [M_DATA_BITS-1:0] m_data,
  output logic                   m_carry,
  output logic                   m_overflow
);

  localparam int M        = M_DATA_BITS;
  localparam int IDX_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [M-1:0] SAT_MAX = {1'b0, {(M-1){1'b1}}};
  localparam logic [M-1:0] SAT_MIN = {1'b1, {(M-1){1'b0}}};
  // Attribute parameters carry no function; they are folded into an always-true term.
  localparam bit ATTR_OK = (DEVICE != "") || (SIMULATION != "") || (DEBUG != "") || (DEBUG == "");

  logic [M-1:0]        acc_r [CHANNELS];
  logic                pv_r  [LATENCY];
  logic [CH_BITS-1:0]  pch_r [LATENCY];
  logic [M-1:0]        pdat_r[LATENCY];
  logic                pcy_r [LATENCY];
  logic                pov_r [LATENCY];

  logic                ch_ok_s;
  logic                op_ok_s;
  logic [IDX_BITS-1:0] idx_s;
  logic [M-1:0]        base_s;
  logic [M-1:0]        data_m_s;
  logic [M:0]          ext_base_s;
  logic [M:0]          ext_data_s;
  logic [M:0]          sum_s;
  logic [M:0]          uns_s;
  logic                ovf_s;
  logic                carry_s;
  logic [M-1:0]        final_s;

  // Stage-1 arithmetic: base select, exact (M+1)-bit result, flags and saturation.
  always_comb begin
    ch_ok_s    = (32'(s_ch) < 32'(CHANNELS)) && ATTR_OK;
    op_ok_s    = s_valid && ch_ok_s;
    idx_s      = s_ch[IDX_BITS-1:0];
    base_s     = CLEAR_DATA;
    sum_s      = {(M+1){1'b0}};
    uns_s      = {(M+1){1'b0}};
    final_s    = {M{1'b0}};
    if (s_clear || s_clear_all || !ch_ok_s) begin
      base_s = CLEAR_DATA;
    end else begin
      base_s = acc_r[idx_s];
    end
    ext_base_s = {base_s[M-1], base_s};
    ext_data_s = {{(M+1-S_DATA_BITS){s_data[S_DATA_BITS-1]}}, s_data};
    data_m_s   = ext_data_s[M-1:0];
    // Subtraction as base + ~data + 1 so carry-out reads as "no borrow".
    if (s_sub) begin
      sum_s = ext_base_s - ext_data_s;
      uns_s = {1'b0, base_s} + {1'b0, ~data_m_s} + {{M{1'b0}}, 1'b1};
    end else begin
      sum_s = ext_base_s + ext_data_s;
      uns_s = {1'b0, base_s} + {1'b0, data_m_s};
    end
    ovf_s   = sum_s[M] ^ sum_s[M-1];
    carry_s = uns_s[M];
    if (SATURATE && ovf_s) begin
      if (sum_s[M]) begin
        final_s = SAT_MIN;
      end else begin
        final_s = SAT_MAX;
      end
    end else begin
      final_s = sum_s[M-1:0];
    end
  end

  // Accumulator bank: reset/clear-all load CLEAR_DATA, an accepted op then overrides its channel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= CLEAR_DATA;
      end
    end else if (cke) begin
      if (s_clear_all) begin
        for (int i = 0; i < CHANNELS; i++) begin
          acc_r[i] <= CLEAR_DATA;
        end
      end
      if (op_ok_s) begin
        acc_r[idx_s] <= final_s;
      end
    end
  end

  // Result pipeline; payload only advances with a valid so outputs hold their last value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv_r[i]   <= 1'b0;
        pch_r[i]  <= {CH_BITS{1'b0}};
        pdat_r[i] <= {M{1'b0}};
        pcy_r[i]  <= 1'b0;
        pov_r[i]  <= 1'b0;
      end
    end else if (cke) begin
      pv_r[0] <= op_ok_s;
      if (op_ok_s) begin
        pch_r[0]  <= s_ch;
        pdat_r[0] <= final_s;
        pcy_r[0]  <= carry_s;
        pov_r[0]  <= ovf_s;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pv_r[i] <= pv_r[i-1];
        if (pv_r[i-1]) begin
          pch_r[i]  <= pch_r[i-1];
          pdat_r[i] <= pdat_r[i-1];
          pcy_r[i]  <= pcy_r[i-1];
          pov_r[i]  <= pov_r[i-1];
        end
      end
    end
  end

  assign m_valid    = pv_r[LATENCY-1];
  assign m_ch       = pch_r[LATENCY-1];
  assign m_data     = pdat_r[LATENCY-1];
  assign m_carry    = pcy_r[LATENCY-1];
  assign m_overflow = pov_r[LATENCY-1];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc_mc.sv
// Bench for elixirchip_es1_spu_op_acc_mc: three instances (M=16 wrap, M=8 saturate, M=8 wrap)
// share one stimulus stream; an integer model feeds per-instance expectation queues.
module tb_elixirchip_es1_spu_op_acc_mc;

  logic       clk = 1'b0;
  logic       reset, cke, s_valid, s_sub, s_clear, s_clear_all;
  logic [2:0] s_ch;
  logic [7:0] s_data;

  logic        mv0, mv1, mv2;
  logic [2:0]  mch0, mch1, mch2;
  logic [15:0] md0;
  logic [7:0]  md1, md2;
  logic        mc0, mc1, mc2, mo0, mo1, mo2;

  typedef struct {
    int due;
    int ch;
    int data;
    bit carry;
    bit ovf;
  } exp_t;

  exp_t q [3][$];
  exp_t exp_last [3];
  bit   exp_mv [3];
  int   acc_m [3][4];
  int   cfg_m [3]   = '{16, 8, 8};
  bit   cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
  int   en_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_acc_mc #(
    .CHANNELS(4), .CH_BITS(3), .S_DATA_BITS(8), .M_DATA_BITS(16), .LATENCY(2), .SATURATE(1'b0)
  ) dut_w16 (
    .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_ch(s_ch), .s_sub(s_sub),
    .s_clear(s_clear), .s_clear_all(s_clear_all), .s_data(s_data),
    .m_valid(mv0), .m_ch(mch0), .m_data(md0), .m_carry(mc0), .m_overflow(mo0)
  );

  elixirchip_es1_spu_op_acc_mc #(
    .CHANNELS(4), .CH_BITS(3), .S_DATA_BITS(8), .M_DATA_BITS(8), .LATENCY(2), .SATURATE(1'b1)
  ) dut_s8 (
    .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_ch(s_ch), .s_sub(s_sub),
    .s_clear(s_clear), .s_clear_all(s_clear_all), .s_data(s_data),
    .m_valid(mv1), .m_ch(mch1), .m_data(md1), .m_carry(mc1), .m_overflow(mo1)
  );

  elixirchip_es1_spu_op_acc_mc #(
    .CHANNELS(4), .CH_BITS(3), .S_DATA_BITS(8), .M_DATA_BITS(8), .LATENCY(2), .SATURATE(1'b0)
  ) dut_w8 (
    .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_ch(s_ch), .s_sub(s_sub),
    .s_clear(s_clear), .s_clear_all(s_clear_all), .s_data(s_data),
    .m_valid(mv2), .m_ch(mch2), .m_data(md2), .m_carry(mc2), .m_overflow(mo2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact integer reference for one operation at width m.
  function automatic void model(input int m, input bit sat, input int base, input int d,
                                input bit sub, output int res, output bit cy, output bit ov);
    int exact, maxv, minv, modv, ub, ud, r;
    modv  = 1 << m;
    maxv  = (modv >> 1) - 1;
    minv  = -(modv >> 1);
    exact = sub ? base - d : base + d;
    ov    = (exact > maxv) || (exact < minv);
    ub    = base & (modv - 1);
    ud    = d & (modv - 1);
    cy    = sub ? (ub >= ud) : ((ub + ud) >= modv);
    if (ov && sat) begin
      res = (exact > maxv) ? maxv : minv;
    end else begin
      r = exact & (modv - 1);
      if (r > maxv) r = r - modv;
      res = r;
    end
  endfunction

  task automatic tick();
    bit rst_now, en_now, cy, ov;
    int base, res, chi, mask;
    exp_t e;
    logic [31:0] o_mv, o_ch, o_data, o_cy, o_ov;
    rst_now = !reset;
    en_now  = reset && cke;
    chi     = int'(s_ch);
    for (int d = 0; d < 3; d++) begin
      if (rst_now) begin
        q[d].delete();
        for (int c = 0; c < 4; c++) acc_m[d][c] = 0;
      end else if (en_now) begin
        if (s_clear_all) for (int c = 0; c < 4; c++) acc_m[d][c] = 0;
        if (s_valid && chi < 4) begin
          base = (s_clear || s_clear_all) ? 0 : acc_m[d][chi];
          model(cfg_m[d], cfg_sat[d], base, int'($signed(s_data)), s_sub, res, cy, ov);
          acc_m[d][chi] = res;
          e.due = en_cnt + 2; e.ch = chi; e.data = res; e.carry = cy; e.ovf = ov;
          q[d].push_back(e);
        end
      end
    end
    if (en_now) en_cnt++;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst_now) begin
        exp_mv[d] = 1'b0;
        exp_last[d] = '{0, 0, 0, 1'b0, 1'b0};
      end else if (en_now) begin
        exp_mv[d] = 1'b0;
        if (q[d].size() > 0 && q[d][0].due == en_cnt) begin
          exp_mv[d] = 1'b1;
          exp_last[d] = q[d].pop_front();
        end
      end
      case (d)
        0: begin o_mv = 32'(mv0); o_ch = 32'(mch0); o_data = 32'(md0); o_cy = 32'(mc0); o_ov = 32'(mo0); end
        1: begin o_mv = 32'(mv1); o_ch = 32'(mch1); o_data = 32'(md1); o_cy = 32'(mc1); o_ov = 32'(mo1); end
        default: begin o_mv = 32'(mv2); o_ch = 32'(mch2); o_data = 32'(md2); o_cy = 32'(mc2); o_ov = 32'(mo2); end
      endcase
      mask = (1 << cfg_m[d]) - 1;
      chk($sformatf("m_valid[dut%0d]", d), o_mv, 32'(exp_mv[d]));
      chk($sformatf("m_ch[dut%0d]", d), o_ch, 32'(exp_last[d].ch));
      chk($sformatf("m_data[dut%0d]", d), o_data, 32'(exp_last[d].data & mask));
      chk($sformatf("m_carry[dut%0d]", d), o_cy, 32'(exp_last[d].carry));
      chk($sformatf("m_overflow[dut%0d]", d), o_ov, 32'(exp_last[d].ovf));
    end
  endtask

  task automatic op(input int ch, input bit sub, input bit clr, input bit clr_all, input int d);
    cke = 1'b1; s_valid = 1'b1; s_ch = 3'(ch); s_sub = sub;
    s_clear = clr; s_clear_all = clr_all; s_data = 8'(d);
    tick();
  endtask

  task automatic idle(input int n);
    cke = 1'b1; s_valid = 1'b0; s_clear = 1'b0; s_clear_all = 1'b0; s_sub = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b0; cke = 1'b0; s_valid = 1'b0; s_ch = 3'd0; s_sub = 1'b0;
    s_clear = 1'b0; s_clear_all = 1'b0; s_data = 8'd0;
    tick();
    cke = 1'b1;
    tick();
    reset = 1'b1;
    idle(1);

    // ch0 running sum 5, 12, 9
    op(0, 1'b0, 1'b0, 1'b0, 5); op(0, 1'b0, 1'b0, 1'b0, 7); op(0, 1'b0, 1'b0, 1'b0, -3);
    idle(3);
    // interleaved channels 100, 1, 200, -2
    op(1, 1'b0, 1'b0, 1'b0, 100); op(2, 1'b0, 1'b0, 1'b0, 1);
    op(1, 1'b0, 1'b0, 1'b0, 100); op(2, 1'b1, 1'b0, 1'b0, 3);
    idle(3);

    // overflow: saturating vs wrapping 8-bit instances
    reset = 1'b0; tick(); reset = 1'b1;
    op(0, 1'b0, 1'b0, 1'b0, 100); op(0, 1'b0, 1'b0, 1'b0, 100);
    op(3, 1'b1, 1'b0, 1'b0, 100); op(3, 1'b1, 1'b0, 1'b0, 100);
    idle(3);

    // clear, clear-all, out-of-range channel
    reset = 1'b0; tick(); reset = 1'b1;
    op(0, 1'b0, 1'b0, 1'b0, 12); op(0, 1'b0, 1'b1, 1'b0, 3);
    op(2, 1'b0, 1'b0, 1'b1, 4);  op(0, 1'b0, 1'b0, 1'b0, 1);
    op(4, 1'b0, 1'b0, 1'b0, 9);  op(1, 1'b0, 1'b0, 1'b0, 2);
    op(0, 1'b0, 1'b0, 1'b0, 1);
    idle(3);

    // clock-enable freeze mid-pipeline; the held s_valid must be ignored
    op(1, 1'b0, 1'b0, 1'b0, 10);
    cke = 1'b0; s_valid = 1'b1; s_ch = 3'd1; s_data = 8'd50;
    repeat (3) tick();
    idle(3);

    // reset with results in flight
    op(2, 1'b0, 1'b0, 1'b0, 7); op(2, 1'b0, 1'b0, 1'b0, 7);
    reset = 1'b0; s_valid = 1'b0; tick(); reset = 1'b1;
    op(2, 1'b0, 1'b0, 1'b0, 1); op(0, 1'b1, 1'b0, 1'b0, 1);
    idle(3);

    // random mix including cke gaps, clears and dropped channel
    repeat (80) begin
      cke         = ($urandom_range(0, 3) != 0);
      s_valid     = 1'($urandom_range(0, 1));
      s_ch        = 3'($urandom_range(0, 4));
      s_sub       = 1'($urandom_range(0, 1));
      s_clear     = ($urandom_range(0, 7) == 0);
      s_clear_all = ($urandom_range(0, 15) == 0);
      s_data      = 8'($urandom);
      tick();
    end
    idle(4);

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("drain[dut%0d]", d), 32'(q[d].size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
